delay_line_ctrl: RTL and testbench

//  Run-time controller for a DYNAMIC_DELAY=1 variable_delay_line. Accepts delay update requests,

---
 rtl/delay_line_ctrl_pkg.sv | 25 ++
 rtl/delay_line_ctrl_sat_counter.sv | 27 ++
 rtl/delay_line_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_delay_line_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// delay_line_ctrl_pkg
// Shared definitions for the delay line controller: FSM state encoding,
// request field width and the settle latency derived from the delay line's
// output register option.
package delay_line_ctrl_pkg;

    // Width of the requested-delay field coming from the settings registers
    localparam int SET_W = 16;

    // Width of the settle counter; large enough for 1 + OUT_REG with OUT_REG in {0,1}
    localparam int SETTLE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_JUMP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RAMP   = 2'd3
    } state_t;

    // Number of clk_en cycles the delay line needs before data_out reflects a new delay
    function automatic logic [SETTLE_W-1:0] settle_latency(input int out_reg);
        return SETTLE_W'(1 + out_reg);
    endfunction

endpackage

// File: rtl/delay_line_ctrl_sat_counter.sv
// delay_line_ctrl_sat_counter
// Saturating up-counter with synchronous clear, used to track how many
// samples have been written into the delay line since reset.
// Ports:
//   clk    in   clock
//   clear  in   synchronous clear (highest priority)
//   inc    in   count enable; ignored once the count reaches MAX
//   count  out  current count, 0..MAX
module delay_line_ctrl_sat_counter #(
    parameter int WIDTH = 9,
    parameter int MAX   = 256
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != WIDTH'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
// Run-time controller for a dynamic-delay variable delay line. Takes delay
// update requests, clamps them to the legal range and applies each either as
// an immediate jump (blanking data_valid while the line settles) or as a ramp
// of at most RAMP_STEP per accepted sample. Requests arriving while busy are
// held in a one-deep pending register (last request wins).
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high
//   clk_en     in   global enable; all state frozen when low
//   stb_in     in   sample strobe (counts only when clk_en is high)
//   set_stb    in   request strobe
//   set_delay  in   requested delay, unsigned, clamped to DEPTH-1
//   set_ramp   in   1: ramp to target, 0: jump
//   delay      out  delay port of the delay line
//   busy       out  operation in progress
//   data_valid out  qualifier for the delay line output
//   primed     out  more samples written since reset than the current delay
//   done       out  one-cycle pulse when a request completes
//   err_range  out  one-cycle pulse when a request was clamped
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter  int DEPTH     = 256,
    parameter  int OUT_REG   = 0,
    parameter  int RAMP_STEP = 1,
    localparam int DW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             stb_in,
    input  logic             set_stb,
    input  logic [SET_W-1:0] set_delay,
    input  logic             set_ramp,
    output logic [DW-1:0]    delay,
    output logic             busy,
    output logic             data_valid,
    output logic             primed,
    output logic             done,
    output logic             err_range
);

    localparam logic [SETTLE_W-1:0] SETTLE_L = settle_latency(OUT_REG);
    localparam logic [DW-1:0]       STEP     = DW'(RAMP_STEP);

    state_t                state, state_next;
    logic [DW-1:0]         target, target_next;
    logic [DW-1:0]         delay_next;
    logic [SETTLE_W-1:0]   settle_cnt, settle_cnt_next;
    logic                  pend_valid, pend_valid_next;
    logic [DW-1:0]         pend_target, pend_target_next;
    logic                  pend_ramp, pend_ramp_next;
    logic                  data_valid_next;
    logic                  done_next;
    logic                  err_next;
    logic [DW:0]           fill;

    logic                  req_clamped;
    logic [DW-1:0]         req_target;
    logic                  launch;
    logic [DW-1:0]         launch_target;
    logic                  launch_ramp;
    logic                  ramp_up;
    logic [DW-1:0]         ramp_diff;
    logic [DW-1:0]         ramp_step;
    logic [DW-1:0]         ramp_delay;

    assign req_clamped = (set_delay >= SET_W'(DEPTH));
    assign req_target  = req_clamped ? DW'(DEPTH - 1) : set_delay[DW-1:0];

    // A fresh request takes precedence over the pending one and discards it
    assign launch        = set_stb | pend_valid;
    assign launch_target = set_stb ? req_target : pend_target;
    assign launch_ramp   = set_stb ? set_ramp   : pend_ramp;

    // Step is limited by the remaining distance so the ramp never overshoots
    assign ramp_up    = (target > delay);
    assign ramp_diff  = ramp_up ? (target - delay) : (delay - target);
    assign ramp_step  = (ramp_diff > STEP) ? STEP : ramp_diff;
    assign ramp_delay = ramp_up ? (delay + ramp_step) : (delay - ramp_step);

    assign busy   = (state != ST_IDLE);
    assign primed = (fill > {1'b0, delay});

    always_comb begin
        state_next       = state;
        target_next      = target;
        delay_next       = delay;
        settle_cnt_next  = settle_cnt;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        pend_ramp_next   = pend_ramp;
        data_valid_next  = data_valid;
        done_next        = 1'b0;
        err_next         = set_stb & req_clamped;

        case (state)
            ST_IDLE: begin
                if (launch) begin
                    pend_valid_next = 1'b0;
                    target_next     = launch_target;
                    if (launch_target == delay) begin
                        done_next = 1'b1;
                    end else if (!launch_ramp) begin
                        state_next = ST_JUMP;
                    end else begin
                        state_next = ST_RAMP;
                    end
                end
            end
            ST_JUMP: begin
                delay_next      = target;
                data_valid_next = 1'b0;
                settle_cnt_next = SETTLE_L;
                state_next      = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Counting down to zero inclusive keeps data_valid low for L+1 cycles
                if (settle_cnt == '0) begin
                    data_valid_next = 1'b1;
                    done_next       = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    settle_cnt_next = settle_cnt - 1'b1;
                end
            end
            ST_RAMP: begin
                if (stb_in) begin
                    delay_next = ramp_delay;
                    if (ramp_delay == target) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The in-flight operation always runs to completion; newer requests just replace the pending one
        if (busy && set_stb) begin
            pend_valid_next  = 1'b1;
            pend_target_next = req_target;
            pend_ramp_next   = set_ramp;
        end
    end

    // Pulses are cleared while clk_en is low so a frozen cycle never repeats done or err_range
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            target      <= '0;
            delay       <= '0;
            settle_cnt  <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            pend_ramp   <= 1'b0;
            data_valid  <= 1'b1;
            done        <= 1'b0;
            err_range   <= 1'b0;
        end else if (clk_en) begin
            state       <= state_next;
            target      <= target_next;
            delay       <= delay_next;
            settle_cnt  <= settle_cnt_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
            pend_ramp   <= pend_ramp_next;
            data_valid  <= data_valid_next;
            done        <= done_next;
            err_range   <= err_next;
        end else begin
            done        <= 1'b0;
            err_range   <= 1'b0;
        end
    end

    delay_line_ctrl_sat_counter #(
        .WIDTH (DW + 1),
        .MAX   (DEPTH)
    ) u_fill (
        .clk   (clk),
        .clear (reset),
        .inc   (stb_in & clk_en),
        .count (fill)
    );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl
// Self-checking bench for delay_line_ctrl (DEPTH=256, OUT_REG=0, RAMP_STEP=2).
// Each request that should complete pushes its expected final delay into a
// queue; a monitor pops one entry per done pulse and compares the delay.
// Clamped requests push into a separate queue consumed on err_range pulses.
module tb_delay_line_ctrl;

    localparam int DEPTH     = 256;
    localparam int OUT_REG   = 0;
    localparam int RAMP_STEP = 2;
    localparam int DW        = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          stb_in;
    logic          set_stb;
    logic [15:0]   set_delay;
    logic          set_ramp;
    logic [DW-1:0] delay;
    logic          busy;
    logic          data_valid;
    logic          primed;
    logic          done;
    logic          err_range;

    int total = 0;
    int bad = 0;
    int done_count = 0;
    int expected_dones = 0;
    logic [DW-1:0] done_q[$];
    int err_q[$];

    delay_line_ctrl #(
        .DEPTH     (DEPTH),
        .OUT_REG   (OUT_REG),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .stb_in     (stb_in),
        .set_stb    (set_stb),
        .set_delay  (set_delay),
        .set_ramp   (set_ramp),
        .delay      (delay),
        .busy       (busy),
        .data_valid (data_valid),
        .primed     (primed),
        .done       (done),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic r);
        set_delay = d;
        set_ramp  = r;
        set_stb   = 1'b1;
        tick();
        set_stb   = 1'b0;
    endtask

    task automatic expectDone(input logic [DW-1:0] d);
        done_q.push_back(d);
        expected_dones++;
    endtask

    task automatic waitDones(input string name, input int budget);
        int c = 0;
        while (done_count < expected_dones && c < budget) begin
            tick();
            c++;
        end
        checkOutput(name, done_count, expected_dones);
    endtask

    // Monitor: consumes expected entries whenever the DUT pulses done or err_range
    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            checkOutput("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                checkOutput("done_delay", delay, done_q.pop_front());
            end
        end
        if (!reset && err_range) begin
            checkOutput("err_expected", err_q.size() > 0, 1);
            if (err_q.size() > 0) begin
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        stb_in    = 1'b0;
        set_stb   = 1'b0;
        set_delay = '0;
        set_ramp  = 1'b0;
        tick(2);

        // Reset state
        checkOutput("rst_delay", delay, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_data_valid", data_valid, 1);
        checkOutput("rst_primed", primed, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_range", err_range, 0);
        reset = 1'b0;

        // T1: ten samples, then jump to 5
        stb_in = 1'b1;
        tick(10);
        stb_in = 1'b0;
        checkOutput("t1_primed_fill", primed, 1);
        expectDone(5);
        applyStimulus(5, 1'b0);
        checkOutput("t1_busy", busy, 1);
        tick();
        checkOutput("t1_delay", delay, 5);
        checkOutput("t1_dv_low1", data_valid, 0);
        tick();
        checkOutput("t1_dv_low2", data_valid, 0);
        tick();
        checkOutput("t1_dv_back", data_valid, 1);
        checkOutput("t1_done_pulse", done, 1);
        tick(2);
        checkOutput("t1_done_once", done_count, 1);
        checkOutput("t1_primed", primed, 1);

        // T2: ramp 5 -> 9 with a sample every third cycle
        expectDone(9);
        applyStimulus(9, 1'b1);
        for (int s = 0; s < 2; s++) begin
            tick(2);
            checkOutput("t2_hold", delay, 5 + 2 * s);
            stb_in = 1'b1;
            tick();
            stb_in = 1'b0;
            checkOutput("t2_delay_step", delay, 7 + 2 * s);
            checkOutput("t2_dv", data_valid, 1);
        end
        checkOutput("t2_idle", busy, 0);
        waitDones("t2_wait", 5);

        // T3: out-of-range request clamps to DEPTH-1
        err_q.push_back(1);
        expectDone(255);
        applyStimulus(300, 1'b0);
        checkOutput("t3_err_pulse", err_range, 1);
        tick();
        checkOutput("t3_err_single", err_range, 0);
        waitDones("t3_wait", 10);
        checkOutput("t3_delay", delay, 255);

        // T4: jump to 0, then ramp to 200 with two requests while busy (last wins)
        expectDone(0);
        applyStimulus(0, 1'b0);
        waitDones("t4_jump_wait", 10);
        stb_in = 1'b1;
        expectDone(200);
        expectDone(80);
        applyStimulus(200, 1'b1);
        tick(5);
        applyStimulus(50, 1'b1);
        tick(3);
        applyStimulus(80, 1'b1);
        waitDones("t4_wait", 400);
        stb_in = 1'b0;
        checkOutput("t4_delay", delay, 80);
        checkOutput("t4_busy", busy, 0);

        // T5: reset mid-ramp at delay 40 with a pending request queued
        stb_in = 1'b1;
        applyStimulus(0, 1'b1);
        applyStimulus(100, 1'b0);
        for (int c = 0; c < 100 && delay != 8'd40; c++) begin
            tick();
        end
        stb_in = 1'b0;
        checkOutput("t5_pre_delay", delay, 40);
        checkOutput("t5_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        checkOutput("t5_delay", delay, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_primed", primed, 0);
        checkOutput("t5_dv", data_valid, 1);
        reset = 1'b0;
        tick(3);
        checkOutput("t5_pending_cleared", busy, 0);
        checkOutput("t5_delay_held", delay, 0);

        // primed: delay 3, rises on the 4th counted sample
        expectDone(3);
        applyStimulus(3, 1'b0);
        waitDones("primed_wait", 10);
        checkOutput("primed_start", primed, 0);
        for (int i = 1; i <= 4; i++) begin
            stb_in = 1'b1;
            tick();
            stb_in = 1'b0;
            checkOutput("primed_step", primed, (i > 3) ? 1 : 0);
        end

        // T6: clk_en low for 5 cycles inside SETTLE
        expectDone(20);
        applyStimulus(20, 1'b0);
        tick();
        checkOutput("t6_delay", delay, 20);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t6_frozen_dv", data_valid, 0);
            checkOutput("t6_frozen_busy", busy, 1);
        end
        clk_en = 1'b1;
        tick();
        checkOutput("t6_dv_still_low", data_valid, 0);
        tick();
        checkOutput("t6_dv_back", data_valid, 1);
        waitDones("t6_wait", 10);
        tick(2);

        checkOutput("done_total", done_count, expected_dones);
        checkOutput("done_q_empty", done_q.size(), 0);
        checkOutput("err_q_empty", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
